// File: rtl/ann_pkg.sv
// Shared constants and state encoding for the ANN spike encoder.
// Step-index width is derived from the timestep count by step_w().
package ann_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int IN_CH_DEF   = 8;
  localparam int T_STEPS_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ENC  = 1'b1
  } enc_state_t;

  function automatic int step_w(input int t_steps);
    return $clog2(t_steps) + 1;
  endfunction

  localparam int STEP_W_DEF = step_w(T_STEPS_DEF);

endpackage

// File: rtl/if_neuron_lane.sv
// One integrate-and-fire channel: clamps the captured input, integrates it
// each timestep and fires with subtractive reset when the threshold is reached.
module if_neuron_lane #(
  parameter int DATA_W = 8,
  parameter int MEM_W  = DATA_W + 2,
  parameter int THRESH = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic                     i_step,
  input  logic signed [DATA_W-1:0] i_data,
  output logic                     o_spike
);

  logic [DATA_W-1:0] r_x;
  logic [MEM_W-1:0]  r_v;

  logic [DATA_W-1:0] w_clamped;
  logic [DATA_W-1:0] w_x;
  logic [MEM_W-1:0]  w_v;
  logic [MEM_W-1:0]  w_vn;
  logic [MEM_W-1:0]  w_v_next;

  assign w_clamped = i_data[DATA_W-1] ? '0 : DATA_W'(i_data);

  // A capture computes step 0 from a cleared membrane and the fresh input,
  // so the first spike is ready on the same edge that loads the lane.
  assign w_x      = i_load ? w_clamped : r_x;
  assign w_v      = i_load ? '0 : r_v;
  assign w_vn     = w_v + MEM_W'(w_x);
  assign o_spike  = (w_vn >= MEM_W'(THRESH));
  assign w_v_next = o_spike ? (w_vn - MEM_W'(THRESH)) : w_vn;

  // NOTE: state registers use non-blocking assignments so every lane and the
  // controller see the pre-edge values of each other within the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_v <= '0;
    end else if (i_load) begin
      r_x <= w_clamped;
      r_v <= w_v_next;
    end else if (i_step) begin
      r_v <= w_v_next;
    end
  end

endmodule

// File: rtl/ann_spike_encoder.sv
// Rate-codes captured C2 vectors into T_STEPS spike beats over valid/ready,
// with a four-phase capture handshake and per-frame vector tracking.
module ann_spike_encoder
  import ann_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int IN_CH     = IN_CH_DEF,
  parameter int T_STEPS   = T_STEPS_DEF,
  parameter int THRESH    = 128,
  parameter int FRAME_PIX = 6,
  parameter int MEM_W     = DATA_W + 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_encoder_req,
  input  logic [IN_CH*DATA_W-1:0] i_encoder_data_flat,
  output logic                    o_encoder_ack,
  output logic                    o_spike_valid,
  input  logic                    i_spike_ready,
  output logic [IN_CH-1:0]        o_spike_vec,
  output logic [$clog2(T_STEPS):0] o_step_idx,
  output logic                    o_vec_last,
  output logic                    o_frame_last
);

  localparam int STEP_W = step_w(T_STEPS);
  localparam int PIX_W  = $clog2(FRAME_PIX + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(T_STEPS - 1);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(FRAME_PIX - 1);

  enc_state_t         r_state;
  logic               r_armed;
  logic               r_ack;
  logic               r_valid;
  logic [IN_CH-1:0]   r_spike_vec;
  logic [STEP_W-1:0]  r_step_idx;
  logic               r_vec_last;
  logic               r_frame_last;
  logic [PIX_W-1:0]   r_pix;

  logic               w_capture;
  logic               w_fire;
  logic               w_advance;
  logic               w_done;
  logic [STEP_W-1:0]  w_step_next;
  logic [IN_CH-1:0]   w_spike;

  assign w_capture   = (r_state == ST_IDLE) && r_armed && i_encoder_req;
  assign w_fire      = (r_state == ST_ENC) && r_valid && i_spike_ready;
  assign w_advance   = w_fire && (r_step_idx != LAST_STEP);
  assign w_done      = w_fire && (r_step_idx == LAST_STEP);
  assign w_step_next = r_step_idx + STEP_W'(1);

  for (genvar c = 0; c < IN_CH; c++) begin : g_lane
    if_neuron_lane #(
      .DATA_W (DATA_W),
      .MEM_W  (MEM_W),
      .THRESH (THRESH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_capture),
      .i_step  (w_advance),
      .i_data  (i_encoder_data_flat[c*DATA_W +: DATA_W]),
      .o_spike (w_spike[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_armed      <= 1'b1;
      r_ack        <= 1'b0;
      r_valid      <= 1'b0;
      r_spike_vec  <= '0;
      r_step_idx   <= '0;
      r_vec_last   <= 1'b0;
      r_frame_last <= 1'b0;
      r_pix        <= '0;
    end else begin
      // The ack/re-arm sequence runs independently of the beat stream.
      if (w_capture) begin
        r_ack   <= 1'b1;
        r_armed <= 1'b0;
      end else if (r_ack && !i_encoder_req) begin
        r_ack   <= 1'b0;
        r_armed <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            r_state      <= ST_ENC;
            r_valid      <= 1'b1;
            r_spike_vec  <= w_spike;
            r_step_idx   <= '0;
            r_vec_last   <= (LAST_STEP == '0);
            r_frame_last <= (LAST_STEP == '0) && (r_pix == LAST_PIX);
          end
        end
        ST_ENC: begin
          if (w_advance) begin
            r_spike_vec  <= w_spike;
            r_step_idx   <= w_step_next;
            r_vec_last   <= (w_step_next == LAST_STEP);
            r_frame_last <= (w_step_next == LAST_STEP) && (r_pix == LAST_PIX);
          end else if (w_done) begin
            r_state      <= ST_IDLE;
            r_valid      <= 1'b0;
            r_spike_vec  <= '0;
            r_step_idx   <= '0;
            r_vec_last   <= 1'b0;
            r_frame_last <= 1'b0;
            r_pix        <= (r_pix == LAST_PIX) ? '0 : r_pix + PIX_W'(1);
          end
        end
      endcase
    end
  end

  assign o_encoder_ack = r_ack;
  assign o_spike_valid = r_valid;
  assign o_spike_vec   = r_spike_vec;
  assign o_step_idx    = r_step_idx;
  assign o_vec_last    = r_vec_last;
  assign o_frame_last  = r_frame_last;

endmodule

// File: tb/tb_ann_spike_encoder.sv
// Self-checking bench: two encoder instances (THRESH 128 and 100) driven with
// directed and random vectors, compared against an arithmetic reference model.
module tb_ann_spike_encoder;

  localparam int T   = 4;
  localparam int FP  = 6;
  localparam int NCH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req   [2];
  logic        ack   [2];
  logic        valid [2];
  logic        ready [2];
  logic        vlast [2];
  logic        flast [2];
  logic [63:0] din   [2];
  logic [7:0]  vec   [2];
  logic [2:0]  step  [2];

  int n_pass  = 0;
  int n_total = 0;
  int pix_exp [2];

  ann_spike_encoder #(.THRESH(128)) u_dut0 (
    .clk(clk), .rst(rst),
    .i_encoder_req(req[0]), .i_encoder_data_flat(din[0]), .o_encoder_ack(ack[0]),
    .o_spike_valid(valid[0]), .i_spike_ready(ready[0]), .o_spike_vec(vec[0]),
    .o_step_idx(step[0]), .o_vec_last(vlast[0]), .o_frame_last(flast[0])
  );

  ann_spike_encoder #(.THRESH(100)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_encoder_req(req[1]), .i_encoder_data_flat(din[1]), .o_encoder_ack(ack[1]),
    .o_spike_valid(valid[1]), .i_spike_ready(ready[1]), .o_spike_vec(vec[1]),
    .o_step_idx(step[1]), .o_vec_last(vlast[1]), .o_frame_last(flast[1])
  );

  function automatic int th_of(input int d);
    return (d == 0) ? 128 : 100;
  endfunction

  // Spike bits at timestep t: integrate x each step from a zero membrane,
  // fire and subtract the threshold whenever the sum reaches it.
  function automatic logic [7:0] model_vec(input logic [63:0] data, input int th, input int t);
    logic [7:0] r;
    int x;
    int v;
    bit sp;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      x = int'($signed(data[c*8 +: 8]));
      if (x < 0) x = 0;
      v  = 0;
      sp = 1'b0;
      for (int s = 0; s <= t; s++) begin
        v  = v + x;
        sp = (v >= th);
        if (sp) v = v - th;
      end
      r[c] = sp;
    end
    return r;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pix_exp[0] = 0;
    pix_exp[1] = 0;
  endtask

  // mode 0: ready always 1; mode 1: ready 0,0,1,0,1,1,1; mode 2: random ready
  task automatic do_vector(input int d, input logic [63:0] data, input int mode, input string tag);
    int cyc;
    int k;
    bit rdy;
    logic [12:0] got;
    logic [12:0] exp_t;
    bit pat [7];
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    @(negedge clk);
    din[d] = data;
    req[d] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ack[d] !== 1'b1 && cyc < 50);
    n_total++;
    if (ack[d] !== 1'b1 || cyc != 1)
      $display("FAIL %s ack_rise: ack=%b after %0d cycles, want 1 after 1", tag, ack[d], cyc);
    else n_pass++;
    req[d] = 1'b0;
    if (ack[d] !== 1'b1) return;
    k = 0;
    cyc = 0;
    while (k < T && cyc < 100) begin
      if (cyc == 1) begin
        n_total++;
        if (ack[d] !== 1'b0) $display("FAIL %s ack_drop: ack=%b, want 0", tag, ack[d]);
        else n_pass++;
      end
      n_total++;
      if (valid[d] !== 1'b1) $display("FAIL %s valid: got %b want 1 (beat %0d)", tag, valid[d], k);
      else n_pass++;
      got   = {vec[d], step[d], vlast[d], flast[d]};
      exp_t = {model_vec(data, th_of(d), k), 3'(k), (k == T-1), (k == T-1) && (pix_exp[d] == FP-1)};
      n_total++;
      if (got !== exp_t)
        $display("FAIL %s beat%0d {vec,step,vlast,flast}: got %h/%0d/%b/%b want %h/%0d/%b/%b", tag, k,
                 got[12:5], got[4:2], got[1], got[0], exp_t[12:5], exp_t[4:2], exp_t[1], exp_t[0]);
      else n_pass++;
      case (mode)
        1:       rdy = (cyc < 7) ? pat[cyc] : 1'b1;
        2:       rdy = 1'($urandom % 2);
        default: rdy = 1'b1;
      endcase
      ready[d] = rdy;
      if (valid[d] === 1'b1 && rdy) k++;
      @(negedge clk);
      cyc++;
    end
    ready[d] = 1'b1;
    n_total++;
    if (k != T) $display("FAIL %s beats: got %0d want %0d", tag, k, T);
    else n_pass++;
    if (k == T) pix_exp[d] = (pix_exp[d] + 1) % FP;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (valid[d] !== 1'b0) $display("FAIL %s extra_beat: valid=%b want 0", tag, valid[d]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; ready[d] = 1'b1; din[d] = '0; pix_exp[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if ({ack[d], valid[d], vec[d], step[d], vlast[d], flast[d]} !== 15'd0)
        $display("FAIL reset dut%0d: ack=%b valid=%b vec=%h step=%0d vlast=%b flast=%b, want all 0",
                 d, ack[d], valid[d], vec[d], step[d], vlast[d], flast[d]);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_vector(0, {8{8'd64}}, 0, "x64");
    do_vector(0, 64'h0000_0000_0000_007F, 0, "ch0_127");
    do_vector(1, 64'h0000_6400_8000_0000, 0, "th100");
  endtask

  task automatic test_backpressure();
    do_vector(0, {$urandom, $urandom}, 1, "backpressure");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) do_vector(0, {$urandom, $urandom}, 2, "rand0");
    for (int i = 0; i < 4; i++) do_vector(1, {$urandom, $urandom}, 2, "rand1");
  endtask

  task automatic test_reset_mid();
    int c;
    @(negedge clk);
    din[0] = {8{8'd64}};
    req[0] = 1'b1;
    ready[0] = 1'b1;
    c = 0;
    while (ack[0] !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    req[0] = 1'b0;
    while (!(valid[0] === 1'b1 && step[0] === 3'd2) && c < 50) begin @(negedge clk); c++; end
    n_total++;
    if (c >= 50) $display("FAIL mid_wait: step 2 not reached, step=%0d valid=%b", step[0], valid[0]);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pix_exp[0] = 0;
    pix_exp[1] = 0;
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if ({valid[d], ack[d], step[d], vec[d]} !== 13'd0)
        $display("FAIL mid_reset dut%0d: valid=%b ack=%b step=%0d vec=%h, want 0", d, valid[d], ack[d], step[d], vec[d]);
      else n_pass++;
    end
    do_vector(0, {$urandom, $urandom}, 0, "after_reset0");
    do_vector(1, {$urandom, $urandom}, 0, "after_reset1");
  endtask

  task automatic test_back_to_back();
    logic [63:0] dq [7];
    int beats;
    int gap;
    int cyc;
    int nfl;
    logic [12:0] got;
    logic [12:0] exp_t;
    for (int i = 0; i < 7; i++) dq[i] = {$urandom, $urandom};
    pulse_reset();
    ready[0] = 1'b1;
    beats = 0; gap = 0; cyc = 0; nfl = 0;
    fork
      begin
        int c;
        for (int i = 0; i < 7; i++) begin
          din[0] = dq[i];
          req[0] = 1'b1;
          c = 0;
          while (ack[0] !== 1'b1 && c < 200) begin @(negedge clk); c++; end
          req[0] = 1'b0;
          c = 0;
          while (ack[0] !== 1'b0 && c < 200) begin @(negedge clk); c++; end
        end
      end
      begin
        while (beats < 7*T && cyc < 400) begin
          @(negedge clk);
          cyc++;
          if (valid[0] === 1'b1) begin
            if (beats > 0 && beats % T == 0) begin
              n_total++;
              if (gap != 1) $display("FAIL b2b_bubble before vec %0d: gap %0d want 1", beats / T, gap);
              else n_pass++;
            end
            got   = {vec[0], step[0], vlast[0], flast[0]};
            exp_t = {model_vec(dq[beats / T], 128, beats % T), 3'(beats % T), (beats % T == T-1),
                     (beats % T == T-1) && ((beats / T) % FP == FP-1)};
            n_total++;
            if (got !== exp_t)
              $display("FAIL b2b beat%0d {vec,step,vlast,flast}: got %h want %h", beats, got, exp_t);
            else n_pass++;
            if (flast[0] === 1'b1) nfl++;
            beats++;
            gap = 0;
          end else begin
            gap++;
          end
        end
      end
    join
    n_total++;
    if (beats != 7*T) $display("FAIL b2b_beats: got %0d want %0d", beats, 7*T);
    else n_pass++;
    n_total++;
    if (nfl != 1) $display("FAIL b2b_frame_last_count: got %0d want 1", nfl);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (valid[0] !== 1'b0) $display("FAIL b2b_tail: valid=%b want 0", valid[0]);
    else n_pass++;
    pix_exp[0] = 7 % FP;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
